// File: rtl/spi_command_engine.sv
// spi_command_engine
//   Decodes one command byte per SPI chip-select frame and bridges the SPI
//   slave to the coax TX/RX datapaths.
//   Command byte: opcode = byte[3:0], argument = byte[7:4].
//     0x2 READ  : stream the register selected by the argument, re-sampled per byte
//     0x3 WRITE : one data byte written to the register selected by the argument
//     0x4 TX    : byte pairs {high, low} become TX words
//     0x5 RX    : drain RX words as {error, empty, pad, data} byte pairs
//   Registers: 0x1 status (RO), 0x2 control (RW), 0xF ID (RO), others read 0.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   spi_cs            chip select, high = deselected (frame abort)
//   spi_rx_data/_strobe  byte from SPI master and its valid pulse
//   spi_tx_data/_strobe  byte for the SPI shifter and its load pulse
//   control           control register
//   tx_data/tx_load   TX FIFO word and push pulse
//   tx_full/tx_active TX FIFO full, transmitter busy
//   rx_reset          receiver reset pulse
//   rx_active/rx_error receiver busy, receiver error latched
//   rx_data/rx_empty  RX FIFO head word and empty flag
//   rx_read_strobe    RX FIFO pop pulse
module spi_command_engine #(
  parameter int         DATA_WIDTH    = 10,
  parameter logic [7:0] ID_VALUE      = 8'hA5,
  parameter logic [7:0] CONTROL_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs,
  input  logic [7:0]            spi_rx_data,
  input  logic                  spi_rx_strobe,
  output logic [7:0]            spi_tx_data,
  output logic                  spi_tx_strobe,
  output logic [7:0]            control,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  input  logic                  tx_full,
  input  logic                  tx_active,
  output logic                  rx_reset,
  input  logic                  rx_active,
  input  logic                  rx_error,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_read_strobe,
  input  logic                  rx_empty
);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_IGNORE = 4'd1;
  localparam logic [3:0] ST_RD1    = 4'd2;
  localparam logic [3:0] ST_RD2    = 4'd3;
  localparam logic [3:0] ST_WR     = 4'd4;
  localparam logic [3:0] ST_TXH    = 4'd5;
  localparam logic [3:0] ST_TXL    = 4'd6;
  localparam logic [3:0] ST_RX1    = 4'd7;
  localparam logic [3:0] ST_RX2    = 4'd8;
  localparam logic [3:0] ST_RX3    = 4'd9;
  localparam logic [3:0] ST_RX4    = 4'd10;

  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_WRITE = 4'h3;
  localparam logic [3:0] OP_TX    = 4'h4;
  localparam logic [3:0] OP_RX    = 4'h5;

  localparam logic [3:0] ADDR_STATUS  = 4'h1;
  localparam logic [3:0] ADDR_CONTROL = 4'h2;
  localparam logic [3:0] ADDR_ID      = 4'hF;

  logic [3:0]            r_state;
  logic [3:0]            r_arg;
  logic [7:0]            r_spi_tx_data;
  logic                  r_spi_tx_strobe;
  logic [7:0]            r_control;
  logic                  r_tx_overflow;
  logic [7:0]            r_tx_high;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_load;
  logic                  r_rx_reset;
  logic                  r_rx_read_strobe;
  logic [15:0]           r_rx_buf;

  logic                  w_rx_strobe;
  logic [7:0]            w_status;
  logic [7:0]            w_reg_rd;
  logic [15:0]           w_rx_word;
  logic [15:0]           w_tx_word;
  logic                  w_unused_tx;

  // A byte arriving while deselected belongs to no frame.
  assign w_rx_strobe = spi_rx_strobe & ~spi_cs;

  assign w_status = {r_tx_overflow, rx_error, rx_active, tx_active,
                     tx_full, rx_empty, 2'b00};

  always_comb begin
    w_reg_rd = '0;
    case (r_arg)
      ADDR_STATUS:  w_reg_rd = w_status;
      ADDR_CONTROL: w_reg_rd = r_control;
      ADDR_ID:      w_reg_rd = ID_VALUE;
      default:      w_reg_rd = '0;
    endcase
  end

  always_comb begin
    w_rx_word                 = '0;
    w_rx_word[DATA_WIDTH-1:0] = rx_data;
    w_rx_word[15]             = rx_error;
    w_rx_word[14]             = rx_empty;
  end

  // Only the low DATA_WIDTH bits of the byte pair reach the TX FIFO.
  assign w_tx_word   = {r_tx_high, spi_rx_data};
  assign w_unused_tx = &{1'b0, w_tx_word[15:DATA_WIDTH]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_arg            <= '0;
      r_spi_tx_data    <= '0;
      r_spi_tx_strobe  <= 1'b0;
      r_control        <= CONTROL_RESET;
      r_tx_overflow    <= 1'b0;
      r_tx_high        <= '0;
      r_tx_data        <= '0;
      r_tx_load        <= 1'b0;
      r_rx_reset       <= 1'b0;
      r_rx_read_strobe <= 1'b0;
      r_rx_buf         <= '0;
    end else begin
      r_spi_tx_strobe  <= 1'b0;
      r_tx_load        <= 1'b0;
      r_rx_reset       <= 1'b0;
      r_rx_read_strobe <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_rx_strobe) begin
            r_arg <= spi_rx_data[7:4];
            case (spi_rx_data[3:0])
              OP_READ:  r_state <= ST_RD1;
              OP_WRITE: r_state <= ST_WR;
              OP_TX:    r_state <= ST_TXH;
              OP_RX:    r_state <= ST_RX1;
              default:  r_state <= ST_IGNORE;
            endcase
          end
        end

        ST_IGNORE: r_state <= ST_IGNORE;

        ST_RD1: begin
          r_spi_tx_data   <= w_reg_rd;
          r_spi_tx_strobe <= 1'b1;
          r_state         <= ST_RD2;
        end

        ST_RD2: begin
          if (w_rx_strobe) r_state <= ST_RD1;
        end

        ST_WR: begin
          if (w_rx_strobe) begin
            if (r_arg == ADDR_CONTROL) begin
              r_control <= {1'b0, spi_rx_data[6:0]};
              if (spi_rx_data[7]) r_tx_overflow <= 1'b0;
            end
            r_state <= ST_IGNORE;
          end
        end

        ST_TXH: begin
          if (w_rx_strobe) begin
            r_tx_high <= spi_rx_data;
            r_state   <= ST_TXL;
          end
        end

        ST_TXL: begin
          if (w_rx_strobe) begin
            if (!tx_full) begin
              r_tx_data <= w_tx_word[DATA_WIDTH-1:0];
              r_tx_load <= 1'b1;
            end else begin
              r_tx_overflow <= 1'b1;
            end
            r_state <= ST_TXH;
          end
        end

        ST_RX1: begin
          r_rx_buf <= w_rx_word;
          r_state  <= ST_RX2;
        end

        ST_RX2: begin
          r_spi_tx_data   <= r_rx_buf[15:8];
          r_spi_tx_strobe <= 1'b1;
          r_state         <= ST_RX3;
        end

        ST_RX3: begin
          if (w_rx_strobe) begin
            r_spi_tx_data   <= r_rx_buf[7:0];
            r_spi_tx_strobe <= 1'b1;
            // Side effect follows the flags captured with the word, not live ones.
            if (r_rx_buf[15])      r_rx_reset       <= 1'b1;
            else if (!r_rx_buf[14]) r_rx_read_strobe <= 1'b1;
            r_state <= ST_RX4;
          end
        end

        ST_RX4: begin
          if (w_rx_strobe) r_state <= ST_RX1;
        end

        default: r_state <= ST_IDLE;
      endcase

      // Deselect aborts the frame; strobes computed above still fire.
      if (spi_cs) r_state <= ST_IDLE;
    end
  end

  assign spi_tx_data    = r_spi_tx_data;
  assign spi_tx_strobe  = r_spi_tx_strobe;
  assign control        = r_control;
  assign tx_data        = r_tx_data;
  assign tx_load        = r_tx_load;
  assign rx_reset       = r_rx_reset;
  assign rx_read_strobe = r_rx_read_strobe;

endmodule

// File: doc/spi_command_engine.md
Name: spi_command_engine

Overview:
- Parametrised successor of the SPI command decoder between the SPI slave and the coax TX/RX datapaths.
- Decodes one command byte per chip-select frame: register read, register write, TX word streaming, and RX word draining.
- Data word width is generic.
- Adds a TX path, a writable control register, and a sticky TX-overflow flag.

Parameters:
- DATA_WIDTH, 10, coax word width carried by TX/RX words; legal range 1..14.
- ID_VALUE, 8'ha5, value returned by register 0xF.
- CONTROL_RESET, 8'h00, reset value of the control register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_cs  in  1  chip select; high means deselected and forces IDLE
- spi_rx_data  in  8  byte received from SPI master
- spi_rx_strobe  in  1  one-cycle pulse; spi_rx_data valid
- spi_tx_data  out  8  byte to load into the SPI shifter
- spi_tx_strobe  out  1  one-cycle load pulse
- control  out  8  control register contents
- tx_data  out  DATA_WIDTH  word to the TX FIFO
- tx_load  out  1  one-cycle push strobe
- tx_full  in  1  TX FIFO full
- tx_active  in  1  transmitter busy
- rx_reset  out  1  one-cycle RX reset pulse
- rx_active  in  1  receiver busy
- rx_error  in  1  receiver error latched
- rx_data  in  DATA_WIDTH  RX FIFO head word
- rx_read_strobe  out  1  one-cycle RX FIFO pop
- rx_empty  in  1  RX FIFO empty

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE
  - spi_tx_data = 0
  - All strobes (spi_tx_strobe, tx_load, rx_reset, rx_read_strobe) = 0
  - control = CONTROL_RESET
  - tx_overflow = 0
- spi_cs high overrides every state: next state is IDLE. Any half-assembled TX word is discarded. Strobes already computed for that cycle still fire.
- Command byte: opcode = byte[3:0], argument = byte[7:4]. Latched on the first spi_rx_strobe in IDLE.
  - Opcodes 2, 3, 4, 5 are defined below.
  - Any other opcode goes to IGNORE, which stays until spi_cs rises.
- Registers:
  - Address 0x1 (status, read-only): {tx_overflow, rx_error, rx_active, tx_active, tx_full, rx_empty, 2'b00}.
  - Address 0x2 (control, read/write).
  - Address 0xF (ID_VALUE, read-only).
  - Any other address reads 0x00.
- READ (0x2): RD1 → RD2 → RD1 ...
  - RD1: sample the selected register into spi_tx_data, pulse spi_tx_strobe, go to RD2. Latency is 2 clk from the command strobe to spi_tx_strobe.
  - RD2: wait for spi_rx_strobe, then go back to RD1. The value is re-sampled every byte.
- WRITE (0x3): WR waits for the data byte.
  - Address 0x2: control <= byte[6:0] with control[7] forced to 0. If byte[7]=1, tx_overflow is cleared in the same cycle.
  - Other addresses: write ignored.
  - Then go to IGNORE. Only one write per frame.
- TX (0x4): TXH → TXL → TXH ...
  - TXH: latch byte as high byte.
  - TXL: on the next byte, form word = {high, low}[DATA_WIDTH-1:0].
    - If !tx_full: tx_data <= word and tx_load pulses the following cycle.
    - If tx_full: word dropped, no tx_load, tx_overflow set (sticky).
  - tx_full is sampled on the cycle the low byte strobes.
- RX (0x5): RX1 → RX2 → RX3 → RX4 → RX1.
  - RX1: buffer <= {rx_error, rx_empty, zero pad, rx_data}, 16 bits total, with rx_data in bits [DATA_WIDTH-1:0].
  - RX2: spi_tx_data = buffer[15:8], strobe.
  - RX3: on spi_rx_strobe, send buffer[7:0] with strobe. Side effect from the buffered flags:
    - buffer[15]=1: pulse rx_reset.
    - else buffer[14]=0: pulse rx_read_strobe.
    - else (empty): no side effect.
  - RX4: on spi_rx_strobe, go to RX1.
- Simultaneous events:
  - spi_rx_strobe in the same cycle as spi_cs high: byte ignored.
  - tx_overflow set and clear in the same cycle: set wins.

Test Plan:
- Reset, then CS low, send 0xF2 and two dummy bytes → spi_tx_data = 0xA5 with spi_tx_strobe 2 clk after each byte strobe; control = 0x00.
- Send 0x23, 0x5A → control = 0x5A. Then read 0x22 → 0x5A. Then send 0x23, 0x81 → control = 0x01 and tx_overflow cleared.
- DATA_WIDTH=10, send 0x04, 0x03, 0xFF, 0x01, 0x23 with tx_full=0 → tx_load twice with tx_data 0x3FF then 0x123. Raise CS after a single trailing byte → no third load.
- Send 0x04, 0x00, 0x07 with tx_full=1 → no tx_load; status read (0x12) bit7 = 1.
- RX FIFO holding 0x2AB, then empty, send 0x05 and four dummy bytes → bytes 0x02, 0xAB, 0x40, 0x00; exactly one rx_read_strobe, no rx_reset.
- rx_error=1, send 0x05 and two dummy bytes → first byte bit7 = 1; rx_reset pulses once, no rx_read_strobe.
